// File: rtl/console_tx_if.sv
// Console byte-channel bundle: NUM_REQ producers offering bytes, one shared 32-bit console word.
interface console_tx_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [31:0]          data_o;
    logic                 timeout_o;

    modport master (
        output req_valid_i, req_data_i,
        input  req_ready_o, grant_o, data_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_data_i,
        output req_ready_o, grant_o, data_o, timeout_o
    );
endinterface

// File: rtl/console_tx_arbiter.sv
// Line-atomic round-robin arbiter for the console byte channel (strobe word, ESC pairs kept together).
// Optional macro CONSOLE_ARB_PRIO0_EN: requester 0 wins arbitration whenever the channel is unlocked.
module console_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    console_tx_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            line_q, line_d;
    logic            esc_q, esc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      byte_q, byte_d;

    logic            locked;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [7:0]      sel_byte;
    logic            accept;
    logic            fire;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + IW'(1);
    endfunction

    assign locked   = line_q | esc_q;
    assign sel_byte = bus.req_data_i[{sel_idx, 3'b000} +: 8];
    assign fire     = (LOCK_TIMEOUT != 0) && (state_q == S_IDLE) && locked && (tmo_q == TMO_MAX);
    assign accept   = (state_q == S_IDLE) && sel_found && !fire;

    // While a line or ESC pair is open only the owner may send; otherwise rotate from rr_q.
    always_comb begin : select
        int j;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        if (locked) begin
            sel_found = bus.req_valid_i[owner_q];
            sel_idx   = owner_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                j = int'(rr_q) + i;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!sel_found && bus.req_valid_i[IW'(j)]) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(j);
                end
            end
`ifdef CONSOLE_ARB_PRIO0_EN
            if (bus.req_valid_i[0]) begin
                sel_found = 1'b1;
                sel_idx   = '0;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            line_q  <= 1'b0;
            esc_q   <= 1'b0;
            tmo_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            line_q  <= line_d;
            esc_q   <= esc_d;
            tmo_q   <= tmo_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin : next_state
        logic nl, ne;
        state_d = state_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        line_d  = line_q;
        esc_d   = esc_q;
        tmo_d   = tmo_q;
        byte_d  = byte_q;
        nl      = line_q;
        ne      = esc_q;

        unique case (state_q)
            S_IDLE: if (accept && sel_byte != 8'hFF) state_d = S_SEND;
            S_SEND: begin
                state_d = S_GAP;
                gap_d   = '0;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // 0xFF is the console idle code: consumed silently, lock state untouched.
        if (accept) begin
            tmo_d = '0;
            if (sel_byte != 8'hFF) begin
                byte_d  = sel_byte;
                owner_d = sel_idx;
                if (esc_q)                   ne = 1'b0;
                else if (sel_byte == 8'h1B)  ne = 1'b1;
                else if (sel_byte == 8'h0A)  nl = 1'b0;
                else if (sel_byte != 8'h0D)  nl = 1'b1;
                line_d = nl;
                esc_d  = ne;
                if (!(nl | ne)) rr_d = next_idx(sel_idx);
            end
        end else if (fire) begin
            line_d = 1'b0;
            esc_d  = 1'b0;
            rr_d   = next_idx(owner_q);
            tmo_d  = '0;
        end else if (!locked) begin
            tmo_d = '0;
        end else if (state_q == S_IDLE && !bus.req_valid_i[owner_q]) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin : outputs
        bus.req_ready_o = '0;
        if (accept && !rst_i) bus.req_ready_o[sel_idx] = 1'b1;
        bus.grant_o   = locked ? (NUM_REQ'(1) << owner_q) : '0;
        bus.data_o    = {state_q == S_SEND, 23'd0, byte_q};
        bus.timeout_o = fire && !rst_i;
    end
endmodule

// File: tb/tb_console_tx_arbiter.sv
// Randomised and directed bench for console_tx_arbiter against a transaction-level reference model.
module tb_console_tx_arbiter;
    localparam int NR  = 4;
    localparam int GAP = 2;
    localparam int LTO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    console_tx_if #(.NUM_REQ(NR)) bus();

    console_tx_arbiter #(
        .NUM_REQ(NR), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(LTO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rq [NR][$];
    bit         stall [NR];
    int         n_checks = 0;
    int         n_fail = 0;

    // reference model: cycle numbers, not states
    int          cyc, busy_until, strobe_cyc, owner, rr, idle_cnt, win;
    bit          line_o, esc_p, m_fire, m_can, m_lk;
    logic [7:0]  last_byte;
    logic [NR-1:0] exp_ready, exp_grant;
    logic [31:0] exp_data;
    logic        exp_tmo;

    logic [31:0]   obs_data [$];
    logic [NR-1:0] obs_grant [$];
    int            obs_cyc [$];
    int            rdy_cyc [NR][$];
    int            tmo_cyc;

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            bus.req_valid_i[k]       = !rst && rq[k].size() > 0 && !stall[k];
            bus.req_data_i[8*k +: 8] = (rq[k].size() > 0) ? rq[k][0] : 8'h00;
        end
    endtask

    task automatic model_reset();
        cyc = 0; busy_until = 0; strobe_cyc = -1; owner = 0; rr = 0; idle_cnt = 0;
        line_o = 0; esc_p = 0; last_byte = 8'h00;
    endtask

    task automatic model_eval();
        m_can     = cyc >= busy_until;
        m_lk      = line_o || esc_p;
        exp_data  = {(strobe_cyc == cyc), 23'd0, last_byte};
        exp_grant = m_lk ? (NR'(1) << owner) : '0;
        m_fire    = m_can && m_lk && (LTO > 0) && (idle_cnt == LTO);
        exp_tmo   = m_fire;
        win = -1;
        if (m_can && !m_fire) begin
            if (m_lk) begin
                if (bus.req_valid_i[owner]) win = owner;
            end else begin
`ifdef CONSOLE_ARB_PRIO0_EN
                if (bus.req_valid_i[0]) win = 0;
`endif
                for (int i = 0; i < NR; i++)
                    if (win < 0 && bus.req_valid_i[(rr + i) % NR]) win = (rr + i) % NR;
            end
        end
        exp_ready = (win >= 0) ? (NR'(1) << win) : '0;
    endtask

    task automatic model_commit();
        logic [7:0] b;
        if (win >= 0) begin
            b = rq[win][0];
            idle_cnt = 0;
            if (b != 8'hFF) begin
                last_byte  = b;
                strobe_cyc = cyc + 1;
                busy_until = cyc + GAP + 2;
                owner      = win;
                if (esc_p)              esc_p  = 0;
                else if (b == 8'h1B)    esc_p  = 1;
                else if (b == 8'h0A)    line_o = 0;
                else if (b != 8'h0D)    line_o = 1;
                if (!(line_o || esc_p)) rr = (win + 1) % NR;
            end
            void'(rq[win].pop_front());
        end else if (m_fire) begin
            line_o = 0; esc_p = 0; rr = (owner + 1) % NR; idle_cnt = 0;
        end else if (m_can && m_lk && !bus.req_valid_i[owner]) begin
            idle_cnt++;
        end else if (!m_lk) begin
            idle_cnt = 0;
        end
        cyc++;
    endtask

    task automatic tick_eval();
        drive();
        @(negedge clk);
        model_eval();
        if (bus.data_o[31]) begin
            obs_data.push_back(bus.data_o);
            obs_grant.push_back(bus.grant_o);
            obs_cyc.push_back(cyc);
        end
        for (int k = 0; k < NR; k++) if (bus.req_ready_o[k]) rdy_cyc[k].push_back(cyc);
        if (bus.timeout_o && tmo_cyc < 0) tmo_cyc = cyc;
    endtask

    task automatic tick_commit();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NR; k++) begin rq[k].delete(); rdy_cyc[k].delete(); stall[k] = 0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        obs_data.delete(); obs_grant.delete(); obs_cyc.delete();
        tmo_cyc = -1;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0:       return 8'h0A;
            1:       return 8'h0D;
            2:       return 8'h1B;
            3:       return 8'hFF;
            default: return 8'h41 + 8'($urandom_range(0, 25));
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_held rdy=%b grant=%b data=%h tmo=%b required all 0",
                     bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_release rdy=%b grant=%b data=%h tmo=%b required all 0",
                     bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o);
        end
    endtask

    task automatic test_line();
        logic [31:0]   want_d [3] = '{32'h80000048, 32'h80000069, 32'h8000000A};
        logic [NR-1:0] want_g [3] = '{4'b0010, 4'b0010, 4'b0000};
        do_reset();
        rq[1] = '{8'h48, 8'h69, 8'h0A};
        for (int c = 0; c < 16; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL line c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
        end
        n_checks++;
        if (obs_data.size() != 3) begin
            n_fail++;
            $display("FAIL line_count got %0d strobes want 3", obs_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_data[i] !== want_d[i] || obs_grant[i] !== want_g[i] || obs_cyc[i] != 1 + 4*i) begin
                    n_fail++;
                    $display("FAIL line_word%0d got %h g=%b @%0d want %h g=%b @%0d", i,
                             obs_data[i], obs_grant[i], obs_cyc[i], want_d[i], want_g[i], 1 + 4*i);
                end
            end
        end
    endtask

    task automatic test_rr_lines();
        logic [31:0] want [4] = '{32'h80000041, 32'h8000000A, 32'h80000042, 32'h8000000A};
        do_reset();
        rq[0] = '{8'h41, 8'h0A};
        rq[2] = '{8'h42, 8'h0A};
        for (int c = 0; c < 20; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL rr c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_data.size() || obs_data[i] !== want[i]) begin
                n_fail++;
                $display("FAIL rr_order%0d got %h want %h", i, (i < obs_data.size()) ? obs_data[i] : 32'hx, want[i]);
            end
        end
        n_checks++;
        if (obs_grant.size() < 3 || obs_grant[2] !== 4'b0100) begin
            n_fail++;
            $display("FAIL rr_grant2 got %b want 0100", (obs_grant.size() > 2) ? obs_grant[2] : 4'bx);
        end
    endtask

    task automatic test_esc();
        logic [31:0]   want   [4] = '{32'h8000001B, 32'h80000004, 32'h8000007A, 32'h8000000A};
        logic [NR-1:0] want_g [2] = '{4'b1000, 4'b0000};
        do_reset();
        rq[3] = '{8'h1B, 8'h04};
        for (int c = 0; c < 20; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL esc c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
            if (c == 0) rq[1] = '{8'h7A, 8'h0A};
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_data.size() || obs_data[i] !== want[i]) begin
                n_fail++;
                $display("FAIL esc_order%0d got %h want %h", i, (i < obs_data.size()) ? obs_data[i] : 32'hx, want[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= obs_grant.size() || obs_grant[i] !== want_g[i]) begin
                n_fail++;
                $display("FAIL esc_grant%0d got %b want %b", i, (i < obs_grant.size()) ? obs_grant[i] : 4'bx, want_g[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rq[1] = '{8'h78};
        for (int c = 0; c < 32; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL tmo c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
            if (c == 2) rq[2] = '{8'h79, 8'h0A};
        end
        n_checks++;
        if (tmo_cyc != 4 + LTO) begin
            n_fail++;
            $display("FAIL tmo_pulse_cycle got %0d want %0d", tmo_cyc, 4 + LTO);
        end
        n_checks++;
        if (rdy_cyc[2].size() == 0 || rdy_cyc[2][0] != 5 + LTO) begin
            n_fail++;
            $display("FAIL tmo_next_accept got %0d want %0d", (rdy_cyc[2].size() > 0) ? rdy_cyc[2][0] : -1, 5 + LTO);
        end
    endtask

    task automatic test_ff();
        do_reset();
        rq[0] = '{8'hFF, 8'h41, 8'h0A};
        for (int c = 0; c < 12; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL ff c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
        end
        n_checks++;
        if (rdy_cyc[0].size() < 2 || rdy_cyc[0][0] != 0 || rdy_cyc[0][1] != 1) begin
            n_fail++;
            $display("FAIL ff_ready_cycles got %0d entries want accepts at 0 and 1", rdy_cyc[0].size());
        end
        n_checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'h80000041 || obs_cyc[0] != 2) begin
            n_fail++;
            $display("FAIL ff_strobe got %0d strobes first=%h want 2 strobes first=80000041 @2",
                     obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rq[1] = '{8'h51};
        tick_eval();
        tick_commit();
        rst = 1'b1;
        drive();
        @(negedge clk);
        n_checks++;
        if (bus.data_o !== 32'h80000051) begin
            n_fail++;
            $display("FAIL rstmid_send got %h want 80000051", bus.data_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        n_checks++;
        if (bus.data_o !== 32'h0 || bus.grant_o !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear got d=%h g=%b want 0 and 0", bus.data_o, bus.grant_o);
        end
        @(posedge clk);
        #1;
        model_reset();
        obs_data.delete();
        rq[1] = '{8'h51, 8'h0A};
        for (int c = 0; c < 12; c++) begin
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL rstmid c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
        end
        n_checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'h80000051) begin
            n_fail++;
            $display("FAIL rstmid_resend got %0d strobes want 2 starting 80000051", obs_data.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c < 1300) begin
                if ($urandom_range(0, 2) == 0) begin
                    int k = $urandom_range(0, NR - 1);
                    if (rq[k].size() < 4) rq[k].push_back(rand_byte());
                end
                for (int k = 0; k < NR; k++) stall[k] = ($urandom_range(0, 3) == 0);
            end else begin
                for (int k = 0; k < NR; k++) stall[k] = 0;
            end
            tick_eval();
            n_checks++;
            if ({bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o} !== {exp_ready, exp_grant, exp_data, exp_tmo}) begin
                n_fail++;
                $display("FAIL rand c%0d got rdy=%b g=%b d=%h t=%b want rdy=%b g=%b d=%h t=%b", cyc,
                         bus.req_ready_o, bus.grant_o, bus.data_o, bus.timeout_o, exp_ready, exp_grant, exp_data, exp_tmo);
            end
            tick_commit();
        end
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        test_reset();
        test_line();
        test_rr_lines();
        test_esc();
        test_timeout();
        test_ff();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/console_tx_arbiter.md
Name: console_tx_arbiter

Overview:
- Shares the single console byte channel (32-bit word: bit 31 = rising-edge strobe, bits 7:0 = byte) among NUM_REQ byte producers, e.g. core CSR writer, debug stub, boot ROM.
- Output is consumed by the simulation console monitor and the UART TX shim.
- Grants are round-robin but line-atomic: a requester owns the channel from its first byte until it sends 0x0A, so text lines never interleave.
- ESC (0x1B) control sequences are kept atomic with their following byte.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, minimum cycles with strobe low after each strobe pulse (>=1).
- LOCK_TIMEOUT, 1024, idle cycles of the lock owner before its lock is forcibly released; 0 disables the timeout.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  NUM_REQ  byte offered by requester k.
- req_data_i  input  8*NUM_REQ  byte of requester k at bits [8k+7:8k].
- req_ready_o  output  NUM_REQ  byte of requester k accepted this cycle (valid & ready).
- grant_o  output  NUM_REQ  one-hot current lock owner; 0 when unlocked.
- data_o  output  32  console word: [31] strobe, [30:8] always 0, [7:0] byte.
- timeout_o  output  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; line_open=0; esc_pending=0; owner=0; timeout counter 0. Reset mid-byte aborts the pending strobe/gap; data_o is 0 after the reset edge.
- Lock state:
  - locked = line_open | esc_pending.
  - grant_o = onehot(owner) when locked, else 0.
- States: IDLE -> SEND (1 cycle) -> GAP (GAP_CYCLES cycles) -> IDLE.
- IDLE selection:
  - If locked, only the owner is eligible.
  - Otherwise pick the first k with req_valid_i[k], searching from rr_ptr upward with wrap.
  - req_ready_o is combinational: high only in IDLE, only for the selected k, only when its valid is high. At most one bit is set.
- Accept at edge t: data_o[7:0] = byte and data_o[31]=1 during cycle t+1 (SEND). data_o[31]=0 during the GAP cycles; data_o[7:0] holds. Minimum byte period is GAP_CYCLES+2.
- Byte 0xFF (console idle code): accepted but not emitted; stays IDLE; lock bookkeeping unchanged.
- Lock update on accept from k (owner=k):
  - esc_pending=1: the byte is emitted as-is; clear esc_pending; line_open unchanged.
  - 0x1B: set esc_pending.
  - 0x0A: clear line_open.
  - 0x0D: line_open unchanged.
  - Any other byte: set line_open.
  - If locked becomes 0 after the update: rr_ptr = (k+1) mod NUM_REQ. rr_ptr changes only on unlock.
- Timeout:
  - Counts while in IDLE, locked, and owner valid low. Resets on any accept and whenever unlocked.
  - At count == LOCK_TIMEOUT: clear line_open and esc_pending, rr_ptr = owner+1, pulse timeout_o, and arbitrate normally the next cycle.
- Non-owner valid while locked: ignored; ready low; data is held by the requester.
- Single requester: back-to-back bytes every GAP_CYCLES+2 cycles.

Optional Feature:
- Macro CONSOLE_ARB_PRIO0_EN.
- Defined: when unlocked, requester 0 wins over round-robin whenever valid (debug stub priority). Requester 0 still cannot preempt an existing lock.
- Undefined: pure round-robin as above.

Test Plan:
- Req1 sends "Hi\n" (0x48,0x69,0x0A); GAP_CYCLES=2 -> strobes 4 cycles apart, data_o = 0x80000048, 0x80000069, 0x8000000A; grant_o=4'b0010 from the first accept until after 0x0A.
- Req0 and req2 both valid from reset, each sending "A\n"/"B\n" -> req0 line fully emitted before any req2 byte; rr_ptr=1 afterwards; req2 served next.
- Req3 sends 0x1B,0x04 with no open line; req1 valid throughout -> both bytes consecutive, no req1 byte between; lock released after 0x04.
- Req1 sends 'x' then stalls, LOCK_TIMEOUT=16 -> timeout_o pulse 16 cycles after the lock-owner-idle count starts; req2's pending byte is accepted the next cycle.
- Req0 sends 0xFF -> ready pulse, no strobe; an immediately following 0x41 strobes 1 cycle after its accept.
- Reset asserted during SEND -> data_o=0 on the next edge; grant_o=0; a re-offered byte is emitted cleanly after reset deasserts.
